i2c_wr_master: RTL and testbench
================================

# i2c_wr_master

Bit-level I2C write engine that executes one register write per request from the codec configuration sequencer. It accepts a 16-bit {register address, data} word on `i2c_exec` and serialises START, slave address + W, register byte, data byte and STOP onto SCL/SDA. It reports completion on `i2c_done` and any missing acknowledge on `i2c_ack`. It sits between the configuration sequencer and the ES8388 control pins. The SDA tri-state buffer is instantiated at the top level.

## Interface
- `SLAVE_ADDR`, default 7'h10: 7-bit ES8388 device address. The first byte on the wire is {SLAVE_ADDR, 1'b0}.
- `clk  in  1`: engine clock, 4× the SCL frequency. One SCL bit period is exactly 4 clk cycles.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `i2c_exec  in  1`: single-cycle request strobe. Sampled only in IDLE.
- `i2c_data  in  16`: [15:8] register address, [7:0] register data. Captured on the cycle `i2c_exec` is accepted.
- `i2c_done  out  1`: single-cycle pulse when the transaction (including STOP) completes.
- `i2c_ack  out  1`: 1 = a NACK was seen in the last transaction. Valid from `i2c_done`, held until the next accepted request.
- `busy  out  1`: high from acceptance until the `i2c_done` cycle, inclusive.
- `scl  out  1`: I2C clock, driven push-pull.
- `sda_out  out  1`: SDA drive value.
- `sda_oe  out  1`: 1 = drive `sda_out`, 0 = release the line (pull-up).
- `sda_in  in  1`: sampled SDA pin.

## Operation
- States: IDLE, START, BYTE, ACK, STOP, DONE.
- Each non-IDLE/DONE state lasts whole bit periods, with a 2-bit quarter counter q = 0..3.
- Byte index b = 0..2 selects the byte being sent:
  - b=0: {SLAVE_ADDR, 0}
  - b=1: i2c_data[15:8]
  - b=2: i2c_data[7:0]
- A 3-bit bit counter runs from 7 down to 0, MSB first.
- IDLE: scl=1, sda_oe=1, sda_out=1. If `i2c_exec`=1: latch data, clear `i2c_ack`, set busy, go to START.
- START (1 period): q0 scl=1 sda=1; q1 scl=1 sda=0; q2 scl=1 sda=0; q3 scl=0 sda=0. Then go to BYTE with b=0, bit=7.
- BYTE (8 periods): q0 scl=0, sda_out=current bit, sda_oe=1; q1 scl=1; q2 scl=1; q3 scl=0. After bit 0, go to ACK.
- ACK (1 period): sda_oe=0 for all four quarters, scl waveform as in BYTE. Sample `sda_in` at q2.
  - 0 and b<2: b+1, go to BYTE.
  - 0 and b=2: go to STOP.
  - 1 (NACK): set `i2c_ack`=1 and go to STOP; remaining bytes are skipped.
- STOP (1 period): q0 scl=0 sda=0 oe=1; q1 scl=1 sda=0; q2 scl=1 sda=1; q3 scl=1 sda=1.
- DONE (1 cycle): `i2c_done`=1, then back to IDLE with `busy`=0.
- `i2c_exec` outside IDLE is ignored; the request is not queued.
- The sequencer may assert `i2c_exec` in the cycle after `i2c_done`; this request must be accepted.

## Timing
- Reset values: scl=1, sda_out=1, sda_oe=1, i2c_done=0, i2c_ack=0, busy=0, state=IDLE.
- Reset asserted mid-transfer returns the outputs to these values immediately (asynchronous). No STOP is generated.
- Acceptance edge = T:
  - START occupies T+1..T+4.
  - Bytes plus ACKs occupy 108 cycles.
  - STOP occupies T+113..T+116.
  - `i2c_done` is high in cycle T+117.
- NACK on the address byte: STOP at T+41..T+44, `i2c_done` at T+45.
- NACK on the register byte: `i2c_done` at T+81.
- SDA changes only in q0 while scl=0; the only exceptions are the START and STOP edges.
- `busy` falls in the cycle after `i2c_done`.

## Test plan
- Write i2c_data=16'h0016, slave ACKs every byte:
  - wire bytes 0x20, 0x00, 0x16, MSB first;
  - START/STOP shapes as specified;
  - `i2c_done` at T+117, `i2c_ack`=0.
- Bench slave never pulls SDA low (NACK on address): only byte 0x20 is sent, STOP at T+41, `i2c_done` at T+45, `i2c_ack`=1. The next accepted request clears `i2c_ack` to 0.
- Drive `i2c_exec` with data 16'h2e3c at T+50 during a busy transfer: no effect on the wire; the original transfer completes unchanged at T+117.
- Back-to-back requests, the second `i2c_exec` in the cycle after `i2c_done`: accepted with no gap; the second START begins the following cycle.
- Data 16'hFFFF: all 16 register/data bits are high on the wire; `sda_oe`=0 only during the ACK periods.
- Reset at T+60: scl=1, sda_oe=1, sda_out=1 within the same cycle. No `i2c_done` is produced. A new request afterwards runs a full correct transaction.

Source files
------------

// File: rtl/i2c_wr_master.sv
// ---------------------------------------------------------------------------
// i2c_wr_master
//
// Bit-level I2C write engine. One request writes one codec register:
//   START, {SLAVE_ADDR, W}, register address, register data, STOP.
// One SCL bit period is four clk cycles (quarters q0..q3). All pin outputs
// are registered from the current state/quarter, so the wire lags the FSM
// by one clk cycle. The SDA tri-state buffer lives at the top level.
//
// Ports
//   clk          engine clock, 4x SCL
//   rst_n        asynchronous active-low reset
//   i2c_exec     single-cycle request strobe (sampled only in IDLE)
//   i2c_data     [15:8] register address, [7:0] register data
//   i2c_done     one-cycle pulse when the transaction (incl. STOP) completes
//   i2c_ack      1 = a NACK was seen in the last transaction
//   busy         high from acceptance through the i2c_done cycle
//   scl          I2C clock, push-pull
//   sda_out      SDA drive value
//   sda_oe       1 = drive sda_out, 0 = release SDA
//   sda_in       sampled SDA pin
//   dbg_state_o  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module i2c_wr_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic [15:0] i2c_data,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        busy,
  output logic        scl,
  output logic        sda_out,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BYTE  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e      state_q;
  logic [1:0]  q_q;      // quarter within the current bit period
  logic [2:0]  bit_q;    // bit being sent, MSB first
  logic [1:0]  byte_q;   // 0: slave address, 1: register, 2: data
  logic [15:0] data_q;

  logic [7:0]  tx_byte;
  logic        cur_bit;

  assign dbg_state_o = state_q;

  always_comb begin
    tx_byte = {SLAVE_ADDR, 1'b0};
    case (byte_q)
      2'd1:    tx_byte = data_q[15:8];
      2'd2:    tx_byte = data_q[7:0];
      default: tx_byte = {SLAVE_ADDR, 1'b0};
    endcase
  end

  assign cur_bit = tx_byte[bit_q];

  // Request handshake: i2c_exec acts as a valid strobe and "ready" is the
  // engine sitting in IDLE (busy low, or the DONE cycle just ended). A strobe
  // seen while not in IDLE is dropped, not queued. i2c_data is captured on the
  // accepting edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      q_q      <= 2'd0;
      bit_q    <= 3'd7;
      byte_q   <= 2'd0;
      data_q   <= 16'h0000;
      scl      <= 1'b1;
      sda_out  <= 1'b1;
      sda_oe   <= 1'b1;
      i2c_done <= 1'b0;
      i2c_ack  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i2c_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          scl     <= 1'b1;
          sda_out <= 1'b1;
          sda_oe  <= 1'b1;
          q_q     <= 2'd0;
          // Drops the cycle after i2c_done unless a new request arrives.
          busy    <= i2c_exec;
          if (i2c_exec) begin
            data_q  <= i2c_data;
            i2c_ack <= 1'b0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          // SDA falls while SCL is high (q1), then SCL drops in q3.
          q_q     <= q_q + 2'd1;
          scl     <= (q_q != 2'd3);
          sda_out <= (q_q == 2'd0);
          sda_oe  <= 1'b1;
          if (q_q == 2'd3) begin
            state_q <= ST_BYTE;
            byte_q  <= 2'd0;
            bit_q   <= 3'd7;
          end
        end

        ST_BYTE: begin
          // SDA only changes at q0 while SCL is low; SCL high in q1/q2.
          q_q     <= q_q + 2'd1;
          scl     <= (q_q == 2'd1) || (q_q == 2'd2);
          sda_out <= cur_bit;
          sda_oe  <= 1'b1;
          if (q_q == 2'd3) begin
            if (bit_q == 3'd0) begin
              state_q <= ST_ACK;
            end else begin
              bit_q <= bit_q - 3'd1;
            end
          end
        end

        ST_ACK: begin
          q_q     <= q_q + 2'd1;
          scl     <= (q_q == 2'd1) || (q_q == 2'd2);
          sda_out <= 1'b1;
          sda_oe  <= 1'b0;
          // Outputs lag by a cycle: at this edge the wire has spent the
          // whole previous cycle in its q2 (SCL high) quarter.
          if (q_q == 2'd3) begin
            if (sda_in) begin
              i2c_ack <= 1'b1;
              state_q <= ST_STOP;
            end else if (byte_q == 2'd2) begin
              state_q <= ST_STOP;
            end else begin
              byte_q  <= byte_q + 2'd1;
              bit_q   <= 3'd7;
              state_q <= ST_BYTE;
            end
          end
        end

        ST_STOP: begin
          // SCL rises in q1, then SDA rises while SCL is high (q2).
          q_q     <= q_q + 2'd1;
          scl     <= (q_q != 2'd0);
          sda_out <= q_q[1];
          sda_oe  <= 1'b1;
          if (q_q == 2'd3) begin
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          scl      <= 1'b1;
          sda_out  <= 1'b1;
          sda_oe   <= 1'b1;
          q_q      <= 2'd0;
          i2c_done <= 1'b1;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wr_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_wr_master
//
// Drives register writes into i2c_wr_master, emulates an ES8388 slave that
// can ACK or NACK a chosen byte, and compares the per-cycle SCL/SDA wire
// against a waveform built directly from the bus protocol description.
// ---------------------------------------------------------------------------
module tb_i2c_wr_master;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i2c_exec = 1'b0;
  logic [15:0] i2c_data = 16'h0000;
  logic        i2c_done;
  logic        i2c_ack;
  logic        busy;
  logic        scl;
  logic        sda_out;
  logic        sda_oe;
  logic        sda_in;
  logic [2:0]  dbg_state;

  i2c_wr_master #(.SLAVE_ADDR(7'h10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i2c_exec    (i2c_exec),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack),
    .busy        (busy),
    .scl         (scl),
    .sda_out     (sda_out),
    .sda_oe      (sda_oe),
    .sda_in      (sda_in),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // -------------------------------------------------------------------------
  // Slave model: counts ACK slots since the last START and pulls SDA low in
  // every slot except the one selected by nack_sel (3 = ACK everything).
  // -------------------------------------------------------------------------
  int   nack_sel   = 3;
  int   ack_slot   = 0;
  logic slave_pull = 1'b0;
  logic prev_oe    = 1'b1;
  logic prev_line  = 1'b1;
  logic sda_line;

  assign sda_line = sda_oe ? sda_out : !slave_pull;
  assign sda_in   = sda_line;

  always @(negedge clk) begin
    if (prev_oe && !sda_oe) begin
      ack_slot   = ack_slot + 1;
      slave_pull = ((ack_slot - 1) != nack_sel);
    end else if (sda_oe) begin
      slave_pull = 1'b0;
    end
    if (scl && sda_oe && prev_line && !sda_line) ack_slot = 0;
    prev_oe   = sda_oe;
    prev_line = sda_line;
  end

  // -------------------------------------------------------------------------
  // Reference waveform: one {scl, oe, sda} entry per clk cycle from T+1 up to
  // the end of STOP. ACK entries have oe=0 and their sda bit is ignored.
  // -------------------------------------------------------------------------
  logic [2:0] exp_q[$];

  function automatic void push_bit_period(input logic oe, input logic v);
    exp_q.push_back({1'b0, oe, v});
    exp_q.push_back({1'b1, oe, v});
    exp_q.push_back({1'b1, oe, v});
    exp_q.push_back({1'b0, oe, v});
  endfunction

  function automatic void build_exp(input logic [15:0] d, input int nb);
    logic [7:0] bytes [3];
    bytes[0] = {7'h10, 1'b0};
    bytes[1] = d[15:8];
    bytes[2] = d[7:0];
    exp_q.delete();
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b010);
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) push_bit_period(1'b1, bytes[b][i]);
      push_bit_period(1'b0, 1'b0);
      if (b == nb) break;
    end
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b111);
  endfunction

  function automatic bit wave_bad(input logic [2:0] obs, input logic [2:0] e);
    if (e[1]) return (obs !== e);
    return (obs[2:1] !== e[2:1]);
  endfunction

  // -------------------------------------------------------------------------
  // Driver + checker for one transaction. Entered at a negedge with the DUT
  // idle; leaves at the negedge of the cycle after i2c_done.
  // -------------------------------------------------------------------------
  task automatic run_txn(input logic [15:0] d, input int nb, input bit inject,
                         input string name);
    logic [2:0] obs;
    logic [2:0] bad_obs;
    logic [2:0] bad_exp;
    int         len;
    int         first_bad;
    int         done_seen;
    int         busy_low;
    nack_sel = nb;
    build_exp(d, nb);
    len = exp_q.size();
    i2c_data = d;
    i2c_exec = 1'b1;
    @(negedge clk);                       // cycle T
    i2c_exec = 1'b0;
    i2c_data = 16'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || i2c_ack !== 1'b0 || i2c_done !== 1'b0) begin
      n_err++;
      $display("FAIL accept[%s]: busy=%b ack=%b done=%b, want busy=1 ack=0 done=0",
               name, busy, i2c_ack, i2c_done);
    end
    first_bad = -1;
    done_seen = 0;
    busy_low  = 0;
    bad_obs   = 3'b000;
    bad_exp   = 3'b000;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);                     // cycle T+n
      obs = {scl, sda_oe, sda_out};
      if (first_bad < 0 && wave_bad(obs, exp_q[n-1])) begin
        first_bad = n;
        bad_obs   = obs;
        bad_exp   = exp_q[n-1];
      end
      if (i2c_done) done_seen++;
      if (!busy) busy_low++;
      if (inject && n == 49) begin
        i2c_exec = 1'b1;
        i2c_data = 16'h2e3c;
      end
      if (inject && n == 50) i2c_exec = 1'b0;
    end
    n_cmp++;
    if (first_bad >= 0) begin
      n_err++;
      $display("FAIL wave[%s] at T+%0d: scl/oe/sda=%b, want %b",
               name, first_bad, bad_obs, bad_exp);
    end
    n_cmp++;
    if (done_seen != 0 || busy_low != 0) begin
      n_err++;
      $display("FAIL during[%s]: early done cycles=%0d busy-low cycles=%0d, want 0/0",
               name, done_seen, busy_low);
    end
    @(negedge clk);                       // cycle T+len+1
    n_cmp++;
    if (i2c_done !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done[%s] at T+%0d: done=%b busy=%b, want 1/1",
               name, len + 1, i2c_done, busy);
    end
    n_cmp++;
    if (i2c_ack !== logic'(nb < 3)) begin
      n_err++;
      $display("FAIL ack[%s]: i2c_ack=%b, want %b", name, i2c_ack, logic'(nb < 3));
    end
    @(negedge clk);                       // cycle T+len+2
    n_cmp++;
    if (busy !== 1'b0 || i2c_done !== 1'b0 || i2c_ack !== logic'(nb < 3)) begin
      n_err++;
      $display("FAIL after[%s]: busy=%b done=%b ack=%b, want 0/0/%b",
               name, busy, i2c_done, i2c_ack, logic'(nb < 3));
    end
  endtask

  task automatic idle_gap(input int cycles, input logic want_ack, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || i2c_done !== 1'b0 || i2c_ack !== want_ack ||
          scl !== 1'b1 || sda_oe !== 1'b1 || sda_out !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle[%s]: %0d bad idle cycles, want 0 (ack held at %b)",
               name, bad, want_ack);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({scl, sda_out, sda_oe, i2c_done, i2c_ack, busy} !== 6'b111000) begin
      n_err++;
      $display("FAIL reset: scl/sda/oe/done/ack/busy=%b, want 111000",
               {scl, sda_out, sda_oe, i2c_done, i2c_ack, busy});
    end
    rst_n = 1'b1;
    idle_gap(3, 1'b0, "post_reset");
  endtask

  task automatic test_basic();
    run_txn(16'h0016, 3, 1'b0, "basic_0016");
    idle_gap(2, 1'b0, "basic");
  endtask

  task automatic test_nack();
    run_txn(16'($urandom), 0, 1'b0, "nack_addr");
    idle_gap(int'($urandom_range(1, 6)), 1'b1, "nack_hold");
    run_txn(16'($urandom), 1, 1'b0, "nack_reg");
    idle_gap(2, 1'b1, "nack_reg");
    run_txn(16'($urandom), 2, 1'b0, "nack_data");
    idle_gap(2, 1'b1, "nack_data");
    run_txn(16'($urandom), 3, 1'b0, "ack_clear");
    idle_gap(2, 1'b0, "ack_clear");
  endtask

  task automatic test_busy_ignore();
    run_txn(16'h5a81, 3, 1'b1, "busy_ignore");
    idle_gap(3, 1'b0, "busy_ignore");
  endtask

  task automatic test_back_to_back();
    run_txn(16'($urandom), 3, 1'b0, "b2b_first");
    run_txn(16'($urandom), 3, 1'b0, "b2b_second");
    idle_gap(2, 1'b0, "b2b");
  endtask

  task automatic test_ffff();
    run_txn(16'hFFFF, 3, 1'b0, "all_ones");
    idle_gap(2, 1'b0, "all_ones");
  endtask

  task automatic test_reset_mid();
    logic [2:0] obs;
    int         bad;
    int         dones;
    nack_sel = 3;
    build_exp(16'h9d42, 3);
    i2c_data = 16'h9d42;
    i2c_exec = 1'b1;
    @(negedge clk);                       // cycle T
    i2c_exec = 1'b0;
    bad = 0;
    for (int n = 1; n <= 59; n++) begin
      @(negedge clk);
      obs = {scl, sda_oe, sda_out};
      if (wave_bad(obs, exp_q[n-1])) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_mid_prefix: %0d wrong cycles before reset, want 0", bad);
    end
    @(posedge clk);                       // edge T+60
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scl, sda_oe, sda_out, busy, i2c_done} !== 5'b11100) begin
      n_err++;
      $display("FAIL reset_mid: scl/oe/sda/busy/done=%b, want 11100",
               {scl, sda_oe, sda_out, busy, i2c_done});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i2c_done || busy || !scl || !sda_oe || !sda_out) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy/bus activity, want 0", dones);
    end
    run_txn(16'($urandom), 3, 1'b0, "after_reset");
    idle_gap(2, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_txn(16'($urandom), int'($urandom_range(0, 3)), 1'b0, "random");
      repeat (int'($urandom_range(0, 5))) @(negedge clk);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence + report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_nack();
    test_busy_ignore();
    test_back_to_back();
    test_ffff();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
